datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 26 ++
 rtl/datapath_regfile.sv | 31 +++
 rtl/datapath.sv | 87 ++++++++
 tb/tb_datapath.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared encodings for the single-cycle datapath.
//   alu_op_t  : ALUControl operation codes
//   imm_src_t : ImmSrc immediate-extension formats
//   FLAG_*    : bit positions inside ALUFlags
package datapath_pkg;
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_ZX8  = 2'b00,
        IMM_ZX12 = 2'b01,
        IMM_BR24 = 2'b10,
        IMM_ZERO = 2'b11
    } imm_src_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] PC_REG = 4'd15;
endpackage

// File: rtl/datapath_regfile.sv
// regfile: 15 x 32-bit registers R0-R14 with two combinational read ports.
//   clk, reset (async active-low), we/wa/wd write port,
//   ra1/ra2 read addresses, r15 value returned for address 15, rd1/rd2 read data.
module regfile
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  wa,
    input  logic [31:0] wd,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic [31:0] r15,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] rf [15];

    // Address 15 is the PC alias, so it is never stored here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) rf[i] <= '0;
        end else if (we && wa != PC_REG) begin
            rf[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == PC_REG) ? r15 : rf[ra1];
    assign rd2 = (ra2 == PC_REG) ? r15 : rf[ra2];
endmodule

// File: rtl/datapath.sv
// datapath: single-cycle datapath with PC register, register file, extender and ALU.
//   clk, reset (async active-low)
//   RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc : control
//   Instr, ReadData : instruction word and data-memory read value
//   ALUFlags {N,Z,C,V}, PC, ALUResult, WriteData : outputs
module datapath
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  RegSrc,
    input  logic        RegWrite,
    input  logic [1:0]  ImmSrc,
    input  logic        ALUSrc,
    input  logic [1:0]  ALUControl,
    input  logic        MemtoReg,
    input  logic        PCSrc,
    input  logic [31:0] Instr,
    input  logic [31:0] ReadData,
    output logic [3:0]  ALUFlags,
    output logic [31:0] PC,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData
);
    logic [31:0] pc_plus4, pc_plus8, rd1, ext_imm, src_b, b_eff, result;
    logic [3:0]  ra1, ra2;
    logic [32:0] sum;
    logic        sub, arith;
    alu_op_t     op;
    logic        unused_instr;

    assign unused_instr = &{1'b0, Instr[31:24]};

    assign pc_plus4 = PC + 32'd4;
    assign pc_plus8 = pc_plus4 + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) PC <= '0;
        else        PC <= PCSrc ? result : pc_plus4;
    end

    assign ra1 = RegSrc[0] ? PC_REG : Instr[19:16];
    assign ra2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];

    regfile u_regfile (
        .clk (clk),
        .reset (reset),
        .we (RegWrite),
        .wa (Instr[15:12]),
        .wd (result),
        .ra1 (ra1),
        .ra2 (ra2),
        .r15 (pc_plus8),
        .rd1 (rd1),
        .rd2 (WriteData)
    );

    always_comb begin
        ext_imm = '0;
        case (imm_src_t'(ImmSrc))
            IMM_ZX8:  ext_imm = {24'b0, Instr[7:0]};
            IMM_ZX12: ext_imm = {20'b0, Instr[11:0]};
            IMM_BR24: ext_imm = {{6{Instr[23]}}, Instr[23:0], 2'b00};
            default:  ext_imm = '0;
        endcase
    end

    assign src_b = ALUSrc ? ext_imm : WriteData;
    assign op    = alu_op_t'(ALUControl);

    // SUB is A + ~B + 1, so the shared adder's carry-out doubles as "no borrow".
    always_comb begin
        sub       = (op == ALU_SUB);
        arith     = (op == ALU_ADD) || (op == ALU_SUB);
        b_eff     = sub ? ~src_b : src_b;
        sum       = {1'b0, rd1} + {1'b0, b_eff} + {32'b0, sub};
        ALUResult = (op == ALU_AND) ? (rd1 & src_b) :
                    (op == ALU_ORR) ? (rd1 | src_b) : sum[31:0];
        ALUFlags         = '0;
        ALUFlags[FLAG_N] = ALUResult[31];
        ALUFlags[FLAG_Z] = (ALUResult == 32'd0);
        ALUFlags[FLAG_C] = arith & sum[32];
        ALUFlags[FLAG_V] = arith & (rd1[31] == b_eff[31]) & (sum[31] != rd1[31]);
    end

    assign result = MemtoReg ? ReadData : ALUResult;
endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        PCSrc;
    logic [31:0] Instr;
    logic [31:0] ReadData;
    logic [3:0]  ALUFlags;
    logic [31:0] PC;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_reg [15];

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    datapath dut (
        .clk (clk),
        .reset (reset),
        .RegSrc (RegSrc),
        .RegWrite (RegWrite),
        .ImmSrc (ImmSrc),
        .ALUSrc (ALUSrc),
        .ALUControl (ALUControl),
        .MemtoReg (MemtoReg),
        .PCSrc (PCSrc),
        .Instr (Instr),
        .ReadData (ReadData),
        .ALUFlags (ALUFlags),
        .PC (PC),
        .ALUResult (ALUResult),
        .WriteData (WriteData)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        return (a == 4'd15) ? m_pc + 32'd8 : m_reg[a];
    endfunction

    // Reference model: plain integer arithmetic on the architectural state.
    task automatic model_eval(output logic [31:0] res, output logic [3:0] fl,
                              output logic [31:0] wd, output logic [31:0] result);
        logic [31:0] a, b, imm;
        longint unsigned ua, ub;
        longint sa, sb, sr;
        logic c, v;
        a  = m_read(RegSrc[0] ? 4'd15 : Instr[19:16]);
        wd = m_read(RegSrc[1] ? Instr[15:12] : Instr[3:0]);
        case (ImmSrc)
            2'd0: imm = {24'd0, Instr[7:0]};
            2'd1: imm = {20'd0, Instr[11:0]};
            2'd2: imm = 32'(longint'($signed(Instr[23:0])) * 4);
            default: imm = 32'd0;
        endcase
        b  = ALUSrc ? imm : wd;
        ua = a; ub = b;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        c = 1'b0; v = 1'b0;
        case (ALUControl)
            2'd0: begin res = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb; v = sr > MAX_S || sr < MIN_S; end
            2'd1: begin res = 32'(ua - ub); c = ua >= ub; sr = sa - sb; v = sr > MAX_S || sr < MIN_S; end
            2'd2: res = a & b;
            default: res = a | b;
        endcase
        fl = {res[31], res == 32'd0, c, v};
        result = MemtoReg ? ReadData : res;
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 15; i++) m_reg[i] = 32'd0;
    endtask

    task automatic tick();
        logic [31:0] res, wd, result;
        logic [3:0] fl;
        model_eval(res, fl, wd, result);
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            if (RegWrite && Instr[15:12] != 4'd15) m_reg[Instr[15:12]] = result;
            m_pc = PCSrc ? result : m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic idle_inputs();
        RegSrc = 2'b00; RegWrite = 1'b0; ImmSrc = 2'b00; ALUSrc = 1'b0;
        ALUControl = 2'b00; MemtoReg = 1'b0; PCSrc = 1'b0;
        Instr = 32'd0; ReadData = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        checks++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected %h", PC, 32'd0); end
        checks++; if (ALUResult !== 32'd0) begin errors++; $display("FAIL reset_alu: got %h expected %h", ALUResult, 32'd0); end
        checks++; if (ALUFlags !== 4'b0100) begin errors++; $display("FAIL reset_flags: got %b expected %b", ALUFlags, 4'b0100); end
        tick();
        checks++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_hold_pc: got %h expected %h", PC, 32'd0); end
    endtask

    task automatic test_pc_count();
        @(negedge clk);
        reset = 1'b1;
        checks++; if (PC !== 32'd0) begin errors++; $display("FAIL release_pc: got %h expected %h", PC, 32'd0); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (PC !== 32'(4 * i)) begin errors++; $display("FAIL pc_count%0d: got %h expected %h", i, PC, 32'(4 * i)); end
        end
    endtask

    task automatic test_add_sub();
        idle_inputs();
        Instr = 32'hE280_1005; ALUSrc = 1'b1; RegWrite = 1'b1;
        #1;
        checks++; if (ALUResult !== 32'd5) begin errors++; $display("FAIL add_imm: got %h expected %h", ALUResult, 32'd5); end
        tick();
        RegWrite = 1'b0; Instr = 32'hE241_1005; ALUControl = 2'b01;
        #1;
        checks++; if (ALUResult !== 32'd0) begin errors++; $display("FAIL sub_res: got %h expected %h", ALUResult, 32'd0); end
        checks++; if (ALUFlags !== 4'b0110) begin errors++; $display("FAIL sub_flags: got %b expected %b", ALUFlags, 4'b0110); end
        ALUControl = 2'b00;
        #1;
        checks++; if (ALUResult !== 32'd10) begin errors++; $display("FAIL r1_read: got %h expected %h", ALUResult, 32'd10); end
    endtask

    task automatic test_pc8();
        idle_inputs();
        RegSrc = 2'b01; ALUSrc = 1'b1;
        #1;
        checks++; if (ALUResult !== m_pc + 32'd8) begin errors++; $display("FAIL pc_plus8: got %h expected %h", ALUResult, m_pc + 32'd8); end
    endtask

    task automatic test_branch();
        logic [31:0] base;
        idle_inputs();
        PCSrc = 1'b1; RegSrc = 2'b01; ImmSrc = 2'b10; ALUSrc = 1'b1;
        Instr = 32'hEAFF_FFFE;
        base = m_pc;
        tick();
        checks++; if (PC !== base) begin errors++; $display("FAIL branch_back: got %h expected %h", PC, base); end
        Instr = 32'hEA00_0002;
        base = m_pc;
        tick();
        checks++; if (PC !== base + 32'd16) begin errors++; $display("FAIL branch_fwd: got %h expected %h", PC, base + 32'd16); end
        PCSrc = 1'b0;
    endtask

    task automatic test_memtoreg();
        idle_inputs();
        MemtoReg = 1'b1; ReadData = 32'hDEAD_BEEF; RegWrite = 1'b1;
        Instr = 32'h0000_2000; RegSrc = 2'b10;
        #1;
        checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL rd_during_wr: got %h expected %h", WriteData, 32'd0); end
        tick();
        RegWrite = 1'b0; MemtoReg = 1'b0; ReadData = 32'd0;
        Instr = 32'h0002_2000; ALUSrc = 1'b1;
        #1;
        checks++; if (ALUResult !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r2_rd1: got %h expected %h", ALUResult, 32'hDEAD_BEEF); end
        checks++; if (WriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r2_rd2: got %h expected %h", WriteData, 32'hDEAD_BEEF); end
    endtask

    task automatic test_r15_write();
        logic [31:0] base;
        idle_inputs();
        RegWrite = 1'b1; MemtoReg = 1'b1; ReadData = 32'h1234_5678;
        Instr = 32'h0000_F000;
        base = m_pc;
        tick();
        checks++; if (PC !== base + 32'd4) begin errors++; $display("FAIL r15_write_pc: got %h expected %h", PC, base + 32'd4); end
        RegWrite = 1'b0; MemtoReg = 1'b0; RegSrc = 2'b10;
        #1;
        checks++; if (WriteData !== base + 32'd12) begin errors++; $display("FAIL r15_read: got %h expected %h", WriteData, base + 32'd12); end
    endtask

    task automatic test_reset_priority();
        idle_inputs();
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        Instr = 32'h0002_0000; ALUSrc = 1'b1;
        #1;
        checks++; if (PC !== 32'd0) begin errors++; $display("FAIL async_pc: got %h expected %h", PC, 32'd0); end
        checks++; if (ALUResult !== 32'd0) begin errors++; $display("FAIL async_reg: got %h expected %h", ALUResult, 32'd0); end
        RegWrite = 1'b1; MemtoReg = 1'b1; ReadData = 32'h0BAD_F00D; Instr = 32'h0003_3000;
        tick();
        RegWrite = 1'b0; MemtoReg = 1'b0;
        #1;
        checks++; if (ALUResult !== 32'd0) begin errors++; $display("FAIL reset_blocks_wr: got %h expected %h", ALUResult, 32'd0); end
        checks++; if (PC !== 32'd0) begin errors++; $display("FAIL reset_prio_pc: got %h expected %h", PC, 32'd0); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] res, wd, result;
        logic [3:0] fl;
        for (int i = 0; i < 300; i++) begin
            RegSrc = 2'($urandom); RegWrite = 1'($urandom); ImmSrc = 2'($urandom);
            ALUSrc = 1'($urandom); ALUControl = 2'($urandom); MemtoReg = 1'($urandom);
            PCSrc = ($urandom_range(0, 7) == 0); Instr = $urandom;
            ReadData = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            #1;
            model_eval(res, fl, wd, result);
            checks++; if (ALUResult !== res) begin errors++; $display("FAIL rnd_alu[%0d]: got %h expected %h", i, ALUResult, res); end
            checks++; if (ALUFlags !== fl) begin errors++; $display("FAIL rnd_flags[%0d]: got %b expected %b", i, ALUFlags, fl); end
            checks++; if (WriteData !== wd) begin errors++; $display("FAIL rnd_wd[%0d]: got %h expected %h", i, WriteData, wd); end
            tick();
            checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, PC, m_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_pc_count();
        test_add_sub();
        test_pc8();
        test_branch();
        test_memtoreg();
        test_r15_write();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
